// File: rtl/wshb_arb_pkg.sv
// Shared types and constants for the two-requester Wishbone SDRAM arbiter.
package wshb_arb_pkg;

    localparam logic [0:0] PORT_VGA  = 1'b0;
    localparam logic [0:0] PORT_MIRE = 1'b1;
    localparam int unsigned ADR_W    = 32;

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        OWN_VGA  = 2'b01,
        OWN_MIRE = 2'b10
    } arb_state_t;

    function automatic arb_state_t own_of(input logic [0:0] idx);
        return (idx == PORT_MIRE) ? OWN_MIRE : OWN_VGA;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone B4 bus bundle with master and slave views.
interface wshb_if
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 4
);
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [ADR_W-1:0]          adr;
    logic [DATA_BYTES*8-1:0]   dat_ms;
    logic [DATA_BYTES*8-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection between vga and mire.
// ARB_ROUND_ROBIN_EN: tie goes to the requester not served last; otherwise vga wins ties.
module arb_pick
    import wshb_arb_pkg::*;
(
    input  logic [1:0] cyc,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic [0:0] last_served,
`endif
    output logic [0:0] winner_c
);

    always_comb begin
        winner_c = PORT_VGA;
        if (cyc[PORT_MIRE] && !cyc[PORT_VGA]) begin
            winner_c = PORT_MIRE;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (cyc[PORT_MIRE] && cyc[PORT_VGA]) begin
            winner_c = ~last_served;
        end
`endif
    end

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Two-port Wishbone arbiter (vga reader, mire writer) in front of the SDRAM controller.
// ARB_ROUND_ROBIN_EN selects round-robin ties; default build is fixed priority vga > mire.
module wshb_sdram_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int DATA_BYTES = 4
)(
    input  logic       sys_clk,
    input  logic       sys_rst,
    wshb_if.slave      wshb_ifs_vga,
    wshb_if.slave      wshb_ifs_mire,
    wshb_if.master     wshb_ifm,
    output logic [1:0] gnt
);

    localparam int unsigned DW = DATA_BYTES * 8;

    arb_state_t state;
    logic [1:0] req;
    logic [0:0] winner_c;

    assign req = {wshb_ifs_mire.cyc, wshb_ifs_vga.cyc};

`ifdef ARB_ROUND_ROBIN_EN
    logic [0:0] last_served;

    arb_pick u_pick (
        .cyc         (req),
        .last_served (last_served),
        .winner_c    (winner_c)
    );
`else
    arb_pick u_pick (
        .cyc      (req),
        .winner_c (winner_c)
    );
`endif

    // Ownership FSM: hold while the owner keeps cyc, hand off directly, else idle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= IDLE;
            gnt   <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            last_served <= PORT_MIRE;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= own_of(winner_c);
                        gnt   <= 2'(own_of(winner_c));
`ifdef ARB_ROUND_ROBIN_EN
                        last_served <= winner_c;
`endif
                    end
                end
                OWN_VGA: begin
                    if (!req[PORT_VGA]) begin
                        if (req[PORT_MIRE]) begin
                            state <= OWN_MIRE;
                            gnt   <= 2'(OWN_MIRE);
`ifdef ARB_ROUND_ROBIN_EN
                            last_served <= PORT_MIRE;
`endif
                        end else begin
                            state <= IDLE;
                            gnt   <= 2'b00;
                        end
                    end
                end
                OWN_MIRE: begin
                    if (!req[PORT_MIRE]) begin
                        if (req[PORT_VGA]) begin
                            state <= OWN_VGA;
                            gnt   <= 2'(OWN_VGA);
`ifdef ARB_ROUND_ROBIN_EN
                            last_served <= PORT_VGA;
`endif
                        end else begin
                            state <= IDLE;
                            gnt   <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    // Zero-latency datapath: owner drives the SDRAM side, responses return to the owner only.
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = ADR_W'(0);
        wshb_ifm.dat_ms = DW'(0);
        wshb_ifm.sel    = DATA_BYTES'(0);
        wshb_ifm.cti    = 3'b000;
        wshb_ifm.bte    = 2'b00;

        wshb_ifs_vga.ack  = 1'b0;
        wshb_ifs_vga.err  = 1'b0;
        wshb_ifs_vga.rty  = 1'b0;
        wshb_ifs_mire.ack = 1'b0;
        wshb_ifs_mire.err = 1'b0;
        wshb_ifs_mire.rty = 1'b0;

        wshb_ifs_vga.dat_sm  = wshb_ifm.dat_sm;
        wshb_ifs_mire.dat_sm = wshb_ifm.dat_sm;

        case (state)
            OWN_VGA: begin
                wshb_ifm.cyc     = wshb_ifs_vga.cyc;
                wshb_ifm.stb     = wshb_ifs_vga.stb;
                wshb_ifm.we      = wshb_ifs_vga.we;
                wshb_ifm.adr     = wshb_ifs_vga.adr;
                wshb_ifm.dat_ms  = wshb_ifs_vga.dat_ms;
                wshb_ifm.sel     = wshb_ifs_vga.sel;
                wshb_ifm.cti     = wshb_ifs_vga.cti;
                wshb_ifm.bte     = wshb_ifs_vga.bte;
                wshb_ifs_vga.ack = wshb_ifm.ack;
                wshb_ifs_vga.err = wshb_ifm.err;
                wshb_ifs_vga.rty = wshb_ifm.rty;
            end
            OWN_MIRE: begin
                wshb_ifm.cyc      = wshb_ifs_mire.cyc;
                wshb_ifm.stb      = wshb_ifs_mire.stb;
                wshb_ifm.we       = wshb_ifs_mire.we;
                wshb_ifm.adr      = wshb_ifs_mire.adr;
                wshb_ifm.dat_ms   = wshb_ifs_mire.dat_ms;
                wshb_ifm.sel      = wshb_ifs_mire.sel;
                wshb_ifm.cti      = wshb_ifs_mire.cti;
                wshb_ifm.bte      = wshb_ifs_mire.bte;
                wshb_ifs_mire.ack = wshb_ifm.ack;
                wshb_ifs_mire.err = wshb_ifm.err;
                wshb_ifs_mire.rty = wshb_ifm.rty;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Randomized self-checking bench for wshb_sdram_arbiter against an ownership-rule model.
module tb_wshb_sdram_arbiter;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] gnt;

    always #5 clk = ~clk;

    wshb_if #(.DATA_BYTES(DB)) vga_bus  ();
    wshb_if #(.DATA_BYTES(DB)) mire_bus ();
    wshb_if #(.DATA_BYTES(DB)) sd_bus   ();

    wshb_sdram_arbiter #(.DATA_BYTES(DB)) dut (
        .sys_clk       (clk),
        .sys_rst       (rst),
        .wshb_ifs_vga  (vga_bus),
        .wshb_ifs_mire (mire_bus),
        .wshb_ifm      (sd_bus),
        .gnt           (gnt)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner 0 = nobody, 1 = vga, 2 = mire; last = most recently granted.
    int owner = 0;
    int last  = 2;

    int active [2];
    int remain [2];
    int gap    [2];

    logic [1:0] prev_gnt;
    logic [1:0] gnt_seq [$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input int p, input logic c, input logic [31:0] a, input logic [2:0] t);
        if (p == 0) begin
            vga_bus.cyc    = c;
            vga_bus.stb    = c;
            vga_bus.we     = 1'($urandom);
            vga_bus.adr    = a;
            vga_bus.dat_ms = 32'($urandom);
            vga_bus.sel    = 4'($urandom);
            vga_bus.cti    = t;
            vga_bus.bte    = 2'($urandom);
        end else begin
            mire_bus.cyc    = c;
            mire_bus.stb    = c;
            mire_bus.we     = 1'($urandom);
            mire_bus.adr    = a;
            mire_bus.dat_ms = 32'($urandom);
            mire_bus.sel    = 4'($urandom);
            mire_bus.cti    = t;
            mire_bus.bte    = 2'($urandom);
        end
    endtask

    task automatic drive_sd(input logic a, input logic e, input logic r);
        sd_bus.ack    = a;
        sd_bus.err    = e;
        sd_bus.rty    = r;
        sd_bus.dat_sm = 32'($urandom);
    endtask

    // Everything the arbiter should present for the current model owner.
    task automatic check_outputs();
        logic [2:0]   rsp;
        logic [127:0] got_m;
        logic [127:0] exp_m;
        check("gnt", gnt, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
        got_m = {sd_bus.cyc, sd_bus.stb, sd_bus.we, sd_bus.adr, sd_bus.dat_ms,
                 sd_bus.sel, sd_bus.cti, sd_bus.bte};
        if (owner == 1) begin
            exp_m = {vga_bus.cyc, vga_bus.stb, vga_bus.we, vga_bus.adr, vga_bus.dat_ms,
                     vga_bus.sel, vga_bus.cti, vga_bus.bte};
            check("mux_vga", got_m, exp_m);
        end else if (owner == 2) begin
            exp_m = {mire_bus.cyc, mire_bus.stb, mire_bus.we, mire_bus.adr, mire_bus.dat_ms,
                     mire_bus.sel, mire_bus.cti, mire_bus.bte};
            check("mux_mire", got_m, exp_m);
        end else begin
            check("idle_cyc_stb", {sd_bus.cyc, sd_bus.stb}, 2'b00);
        end
        rsp = {sd_bus.ack, sd_bus.err, sd_bus.rty};
        check("rsp_vga",  {vga_bus.ack, vga_bus.err, vga_bus.rty},    (owner == 1) ? rsp : 3'b000);
        check("rsp_mire", {mire_bus.ack, mire_bus.err, mire_bus.rty}, (owner == 2) ? rsp : 3'b000);
        check("dat_sm", {vga_bus.dat_sm, mire_bus.dat_sm}, {sd_bus.dat_sm, sd_bus.dat_sm});
        if (gnt != 2'b00 && gnt != prev_gnt) gnt_seq.push_back(gnt);
        prev_gnt = gnt;
    endtask

    // Owner keeps the bus while requesting; otherwise choose among current requesters.
    task automatic model_step();
        logic [2:0] want;
        int nxt;
        want = {mire_bus.cyc, vga_bus.cyc, 1'b0};
        if (owner != 0 && want[owner]) begin
            nxt = owner;
        end else if (want[1] && want[2]) begin
`ifdef ARB_ROUND_ROBIN_EN
            nxt = (last == 1) ? 2 : 1;
`else
            nxt = 1;
`endif
        end else if (want[1]) begin
            nxt = 1;
        end else if (want[2]) begin
            nxt = 2;
        end else begin
            nxt = 0;
        end
        if (nxt != 0 && nxt != owner) last = nxt;
        owner = nxt;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        for (int p = 0; p < 2; p++) begin
            if (active[p] != 0 && owner == p + 1 && sd_bus.ack) begin
                remain[p]--;
                if (remain[p] == 0) begin
                    active[p] = 0;
                    gap[p]    = 1;
                end
            end
        end
        model_step();
        #1;
    endtask

    task automatic model_clear();
        owner    = 0;
        last     = 2;
        prev_gnt = 2'b00;
        for (int p = 0; p < 2; p++) begin
            active[p] = 0;
            remain[p] = 0;
            gap[p]    = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_req(0, 1'b0, 32'h0, 3'b000);
        drive_req(1, 1'b0, 32'h0, 3'b000);
        drive_sd(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_cyc_stb", {sd_bus.cyc, sd_bus.stb}, 2'b00);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic run_bursts(input int n, input int start_pct, input int ack_pct,
                              input int minlen, input int maxlen, input int err_pct);
        logic a;
        logic e;
        logic r;
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (active[p] == 0) begin
                    if (gap[p] != 0) begin
                        gap[p] = 0;
                    end else if (int'($urandom_range(99)) < start_pct) begin
                        active[p] = 1;
                        remain[p] = int'($urandom_range(maxlen, minlen));
                    end
                end
                drive_req(p, active[p] != 0, 32'($urandom),
                          (remain[p] > 1) ? 3'b010 : 3'b111);
            end
            a = int'($urandom_range(99)) < ack_pct;
            e = !a && (int'($urandom_range(99)) < err_pct);
            r = !a && !e && (int'($urandom_range(99)) < 5);
            drive_sd(a, e, r);
            cycle();
        end
    endtask

    initial begin
        model_clear();

        // Single vga request at 0x100.
        do_reset();
        drive_req(0, 1'b1, 32'h100, 3'b000);
        drive_sd(1'b1, 1'b0, 1'b0);
        cycle();
        check("r040_gnt", gnt, 2'b01);
        check("r040_adr", sd_bus.adr, 32'h100);
        check("r040_ack_vga", vga_bus.ack, 1'b1);
        check("r040_ack_mire", mire_bus.ack, 1'b0);
        cycle();
        drive_req(0, 1'b0, 32'h0, 3'b000);
        cycle();
        check("r040_idle", gnt, 2'b00);

        // Tie right after reset, then handoff with no idle bubble.
        do_reset();
        drive_req(0, 1'b1, 32'h200, 3'b000);
        drive_req(1, 1'b1, 32'h300, 3'b000);
        cycle();
        check("r041_first", gnt, 2'b01);
        drive_req(0, 1'b0, 32'h0, 3'b000);
        cycle();
        check("r041_handoff", gnt, 2'b10);

        // mire mid-burst is not pre-empted by vga.
        drive_req(0, 1'b1, 32'h400, 3'b000);
        drive_sd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_req(1, 1'b1, 32'h300 + 32'(i * 4), 3'b010);
            cycle();
            check("r043_hold", gnt, 2'b10);
            check("r043_vga_ack", vga_bus.ack, 1'b0);
        end
        drive_req(1, 1'b0, 32'h0, 3'b000);
        cycle();
        check("r043_release", gnt, 2'b01);

        // SDRAM error goes only to the owner.
        drive_req(1, 1'b1, 32'h500, 3'b000);
        drive_sd(1'b0, 1'b1, 1'b0);
        cycle();
        check("r045_err_vga", vga_bus.err, 1'b1);
        check("r045_err_mire", mire_bus.err, 1'b0);
        check("r045_gnt", gnt, 2'b01);

        // Asynchronous reset pulse during a mire burst.
        do_reset();
        drive_req(1, 1'b1, 32'h600, 3'b010);
        drive_sd(1'b1, 1'b0, 1'b0);
        cycle();
        cycle();
        check("r044_pre", gnt, 2'b10);
        #2 rst = 1'b1;
        #1;
        check("r044_gnt", gnt, 2'b00);
        check("r044_cyc", sd_bus.cyc, 1'b0);
        check("r044_mire_ack", mire_bus.ack, 1'b0);
        drive_req(0, 1'b0, 32'h0, 3'b000);
        drive_req(1, 1'b0, 32'h0, 3'b000);
        #2 rst = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        drive_req(0, 1'b1, 32'h700, 3'b000);
        drive_req(1, 1'b1, 32'h800, 3'b000);
        cycle();
        check("r044_tie", gnt, 2'b01);

        // Both requesters doing back-to-back 4-word bursts.
        do_reset();
        gnt_seq.delete();
        run_bursts(40, 100, 100, 4, 4, 0);
        check("r042_len", gnt_seq.size() >= 4, 1'b1);
        if (gnt_seq.size() >= 4) begin
            check("r042_seq", {gnt_seq[0], gnt_seq[1], gnt_seq[2], gnt_seq[3]}, 8'b01_10_01_10);
        end

        // Random traffic with random acks, errors and retries.
        do_reset();
        run_bursts(400, 30, 60, 1, 4, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wshb_sdram_arbiter.md
WSHB_SDRAM_ARBITER -- requirements
Module: wshb_sdram_arbiter

Interface
- REQ-001 Parameter DATA_BYTES, default 4, Wishbone data width in bytes, passed to all three wshb_if ports.
- REQ-002 sys_clk  input  1  system clock (100 MHz); the block has only this clock.
- REQ-003 sys_rst  input  1  reset, asynchronous, active-high.
- REQ-004 wshb_ifs_vga  wshb_if.slave  DATA_BYTES*8 data  requester 0, the VGA frame-buffer reader.
- REQ-005 wshb_ifs_mire  wshb_if.slave  DATA_BYTES*8 data  requester 1, the test-pattern / stream writer.
- REQ-006 wshb_ifm  wshb_if.master  DATA_BYTES*8 data  shared port toward the SDRAM controller (wshb_if_sdram).
- REQ-007 gnt  output  2  one-hot owner status: bit0 = vga, bit1 = mire, 00 = idle.

Function
- REQ-010 The FSM SHALL have exactly three states: IDLE, OWN_VGA and OWN_MIRE, held in a register on sys_clk.
- REQ-011 In IDLE, if any requester asserts cyc, the FSM SHALL enter the winner's OWN state on the next edge.
- REQ-012 When both requesters assert cyc in the same cycle, the winner SHALL be the one not served last (round-robin, see REQ-030).
- REQ-013 In an OWN state, the FSM SHALL stay while the owner's cyc = 1; ownership is never pre-empted mid-cycle or mid-burst.
- REQ-014 When the owner drops cyc and the other requester has cyc = 1, the FSM SHALL go directly to the other OWN state on that edge (no idle bubble).
- REQ-015 When the owner drops cyc and the other requester is idle, the FSM SHALL return to IDLE.
- REQ-016 The last_served register SHALL update to the new owner on every IDLE-to-OWN or OWN-to-OWN transition.
- REQ-017 Master-side signals cyc, stb, we, adr, dat_ms, sel, cti and bte SHALL be combinationally muxed from the owner; in IDLE, cyc and stb SHALL be 0.
- REQ-018 ack, err and rty SHALL be routed to the owner only and forced to 0 toward the non-owner; dat_sm SHALL be broadcast to both.
- REQ-019 Grant latency SHALL be one cycle: cyc asserted at edge n means wshb_ifm.cyc at edge n+1 at the earliest.
- REQ-020 The arbiter SHALL add no latency on ack; it is combinational pass-through from the SDRAM side to the owner.
- REQ-021 gnt SHALL equal the decoded FSM state.

Reset
- REQ-025 While sys_rst = 1, the block SHALL asynchronously force state to IDLE, gnt to 00 and wshb_ifm.cyc/stb to 0.
- REQ-026 While sys_rst = 1, last_served SHALL be forced to mire, so vga wins the first tie.
- REQ-027 A reset asserted mid-transaction SHALL abort ownership immediately; the requester sees no further ack.

Configuration
- REQ-030 With ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin (REQ-012, REQ-016).
- REQ-031 With ARB_ROUND_ROBIN_EN undefined, arbitration SHALL use fixed priority, vga > mire, on every tie and handoff, and last_served SHALL not be implemented.

Structure
- REQ-035 The package wshb_arb_pkg SHALL hold the state enum typedef (IDLE, OWN_VGA, OWN_MIRE) and the port index constants PORT_VGA = 0 and PORT_MIRE = 1.
- REQ-036 Winner selection SHALL live in the sub-module arb_pick, which takes the two cyc bits and last_served and returns the winner index, combinationally.

Verification
- REQ-040 Only vga raises cyc/stb with adr = 0x100 → at the next edge gnt = 01 and wshb_ifm.adr = 0x100; ack reaches vga only.
- REQ-041 Both requesters raise cyc in the same cycle right after reset → vga owns first (gnt = 01); after vga drops cyc, gnt = 10 on the very next edge.
- REQ-042 Both requesters request continuously, each doing 4-word bursts → grants alternate 01, 10, 01, 10 with RR; with ARB_ROUND_ROBIN_EN undefined, mire is served only when vga cyc = 0.
- REQ-043 mire owns and is mid-burst (cti = 010) when vga raises cyc → gnt stays 10 until mire drops cyc, and vga sees ack = 0 throughout.
- REQ-044 sys_rst is pulsed asynchronously (between edges) during a mire burst → gnt = 00 and wshb_ifm.cyc = 0 immediately; after release, a tie is won by vga.
- REQ-045 SDRAM asserts err during a vga cycle → err reaches vga only; mire err stays 0 and ownership is unchanged.
